// File: rtl/pipe_trace_buffer_pkg.sv
// Shared encodings for the pipeline trace recorder: FSM states and probe channel slots.
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DUMP    = 2'd3
  } trace_state_e;

  // Channel c of a sample occupies bits [c*DATA_W +: DATA_W].
  localparam int CH_IPC    = 0;
  localparam int CH_IINST  = 1;
  localparam int CH_INST   = 2;
  localparam int CH_EALU   = 3;
  localparam int CH_MALU   = 4;
  localparam int CH_REGDIN = 5;

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Capture-control, probe and dump-port bundle between the CPU side and the trace buffer.
interface pipe_trace_if #(
  parameter int DATA_W = 32,
  parameter int CH     = 6,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                 arm;
  logic                 sample_en;
  logic                 trig;
  logic [AW-1:0]        post_cnt;
  logic [CH*DATA_W-1:0] probe;

  // rd_data/rd_last are valid while rd_valid=1; a sample moves on the rising edge
  // where rd_valid && rd_ready, and is held stable while rd_valid=1 and rd_ready=0.
  logic                 rd_ready;
  logic                 rd_valid;
  logic [CH*DATA_W-1:0] rd_data;
  logic                 rd_last;

  logic [1:0]           state;
  logic                 wrapped;
  logic [AW:0]          count;

  modport master (
    output arm, sample_en, trig, post_cnt, probe, rd_ready,
    input  rd_valid, rd_data, rd_last, state, wrapped, count
  );

  modport slave (
    input  arm, sample_en, trig, post_cnt, probe, rd_ready,
    output rd_valid, rd_data, rd_last, state, wrapped, count
  );
endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Sample store: one write port, one synchronous read port, contents never reset.
module trace_ram #(
  parameter int W     = 192,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // rdata only changes when re=1, so it doubles as the prefetch holding register.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture with post-trigger window, streamed out oldest-first over valid/ready.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH     = 6,
  parameter int DEPTH  = 16
) (
  input logic         clk,
  input logic         rst_n,
  pipe_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CH * DATA_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_e  state;
  logic [AW-1:0] wptr, rptr, rem;
  logic [AW:0]   count, iss_left;
  logic          wrapped;
  logic          q_valid, q_last;
  logic [SW-1:0] q_data;
  logic          rd_valid, rd_last;
  logic [SW-1:0] rd_data;

  logic          wr_en, finish_cap, advance, rd_en, wrap_nxt;
  logic [AW-1:0] wptr_nxt;
  logic [AW:0]   count_nxt;

  always_comb begin
    wr_en      = ((state == ST_CAPTURE) || (state == ST_POST)) && bus.sample_en && !bus.arm;
    wptr_nxt   = wptr + 1'b1;
    wrap_nxt   = wrapped || (&wptr);
    count_nxt  = (count == FULL) ? FULL : count + 1'b1;
    finish_cap = wr_en && (((state == ST_CAPTURE) && bus.trig && (bus.post_cnt == '0)) ||
                           ((state == ST_POST) && (rem == AW'(1))));
    // Output register and RAM prefetch move together whenever the output slot frees up.
    advance    = !rd_valid || bus.rd_ready;
    rd_en      = (state == ST_DUMP) && advance && (iss_left != '0);
  end

  trace_ram #(.W(SW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (bus.probe),
    .re    (rd_en),
    .raddr (rptr),
    .rdata (q_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      rem      <= '0;
      count    <= '0;
      iss_left <= '0;
      wrapped  <= 1'b0;
      q_valid  <= 1'b0;
      q_last   <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wptr    <= '0;
          count   <= '0;
          wrapped <= 1'b0;
          if (bus.arm) state <= ST_CAPTURE;
        end
        ST_CAPTURE, ST_POST: begin
          if (bus.arm) begin
            wptr    <= '0;
            count   <= '0;
            wrapped <= 1'b0;
            state   <= ST_CAPTURE;
          end else if (wr_en) begin
            wptr    <= wptr_nxt;
            count   <= count_nxt;
            wrapped <= wrap_nxt;
            if (finish_cap) begin
              // Dump window starts at the oldest surviving sample.
              state    <= ST_DUMP;
              rptr     <= wrap_nxt ? wptr_nxt : '0;
              iss_left <= count_nxt;
              q_valid  <= 1'b0;
              q_last   <= 1'b0;
            end else if ((state == ST_CAPTURE) && bus.trig) begin
              rem   <= bus.post_cnt;
              state <= ST_POST;
            end else if (state == ST_POST) begin
              rem <= rem - 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (rd_en) begin
            rptr     <= rptr + 1'b1;
            iss_left <= iss_left - 1'b1;
          end
          if (advance) begin
            q_valid  <= rd_en;
            q_last   <= (iss_left == (AW+1)'(1));
            rd_valid <= q_valid;
            rd_data  <= q_data;
            rd_last  <= q_last;
          end
          if (rd_valid && bus.rd_ready && rd_last) begin
            state    <= ST_IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.state    = state;
  assign bus.wrapped  = wrapped;
  assign bus.count    = count;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.rd_last  = rd_last;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed and randomized capture/dump scenarios against a sample-history reference model.
module tb_pipe_trace_buffer;
  import pipe_trace_pkg::*;

  localparam int DATA_W = 8;
  localparam int CH     = 2;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int SW     = CH * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipe_trace_if #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) bus ();

  pipe_trace_buffer #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rep(input logic [7:0] k);
    return {k, k};
  endfunction

  task automatic do_arm(input logic with_trig);
    bus.arm = 1'b1;
    bus.trig = with_trig;
    bus.sample_en = with_trig;
    cycle();
    bus.arm = 1'b0;
    bus.trig = 1'b0;
    bus.sample_en = 1'b0;
    hist.delete();
  endtask

  task automatic put_sample(input logic [SW-1:0] val, input logic en, input logic tr);
    bus.sample_en = en;
    bus.trig = tr;
    bus.probe = val;
    cycle();
    if (en) hist.push_back(val);
    bus.sample_en = 1'b0;
    bus.trig = 1'b0;
  endtask

  // The dumped window is simply the last DEPTH qualified samples since arm.
  task automatic build_exp(input string tag);
    int n, first;
    n = hist.size();
    first = (n > DEPTH) ? n - DEPTH : 0;
    exp_q.delete();
    for (int i = first; i < n; i++) exp_q.push_back(hist[i]);
    check({tag, " count"}, 32'(bus.count), 32'((n > DEPTH) ? DEPTH : n));
    check({tag, " wrapped"}, 32'(bus.wrapped), 32'(n >= DEPTH));
  endtask

  task automatic run_dump(input string tag, input int mode);
    logic ptn [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic rdy, done, held_v, held_l, seen, bubble;
    logic [SW-1:0] held_d, exp;
    int guard, pidx;
    done = 1'b0; held_v = 1'b0; seen = 1'b0; bubble = 1'b0;
    held_d = '0; held_l = 1'b0; guard = 0; pidx = 0;
    while (!done && guard < 200) begin
      if (bus.rd_valid) seen = 1'b1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = seen ? ptn[pidx % 5] : 1'b0;
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (seen) pidx++;
      bus.rd_ready = rdy;
      if (held_v) begin
        check({tag, " stall valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, " stall data"}, 32'(bus.rd_data), 32'(held_d));
        check({tag, " stall last"}, 32'(bus.rd_last), 32'(held_l));
      end
      if (mode == 0 && seen && !bus.rd_valid) bubble = 1'b1;
      held_v = 1'b0;
      if (bus.rd_valid) begin
        if (rdy) begin
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          check({tag, " data"}, 32'(bus.rd_data), 32'(exp));
          check({tag, " last"}, 32'(bus.rd_last), 32'(exp_q.size() == 0));
          if (bus.rd_last) done = 1'b1;
        end else begin
          held_v = 1'b1;
          held_d = bus.rd_data;
          held_l = bus.rd_last;
        end
      end
      cycle();
      guard++;
    end
    bus.rd_ready = 1'b0;
    check({tag, " dump finished"}, 32'(done), 32'd1);
    check({tag, " samples left"}, 32'(exp_q.size()), 32'd0);
    check({tag, " state after dump"}, 32'(bus.state), 32'(ST_IDLE));
    check({tag, " valid after dump"}, 32'(bus.rd_valid), 32'd0);
    if (mode == 0) check({tag, " no bubbles"}, 32'(bubble), 32'd0);
  endtask

  initial begin
    bus.arm = 1'b0; bus.sample_en = 1'b0; bus.trig = 1'b0;
    bus.post_cnt = '0; bus.probe = '0; bus.rd_ready = 1'b0;

    // Reset values
    repeat (2) cycle();
    check("reset state", 32'(bus.state), 32'(ST_IDLE));
    check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset rd_data", 32'(bus.rd_data), 32'd0);
    check("reset rd_last", 32'(bus.rd_last), 32'd0);
    check("reset count", 32'(bus.count), 32'd0);
    check("reset wrapped", 32'(bus.wrapped), 32'd0);
    rst_n = 1'b1;
    cycle();

    // No-wrap capture, including first-valid latency
    do_arm(1'b0);
    check("nowrap armed", 32'(bus.state), 32'(ST_CAPTURE));
    bus.post_cnt = '0;
    put_sample(16'h1111, 1'b1, 1'b0);
    put_sample(16'h2222, 1'b1, 1'b0);
    put_sample(16'h3333, 1'b1, 1'b1);
    check("nowrap to dump", 32'(bus.state), 32'(ST_DUMP));
    build_exp("nowrap");
    check("nowrap latency0", 32'(bus.rd_valid), 32'd0);
    cycle();
    check("nowrap latency1", 32'(bus.rd_valid), 32'd0);
    cycle();
    check("nowrap latency2", 32'(bus.rd_valid), 32'd1);
    check("nowrap count frozen", 32'(bus.count), 32'd3);
    run_dump("nowrap", 0);

    // Wrap plus post-trigger
    do_arm(1'b0);
    bus.post_cnt = AW'(2);
    for (int k = 1; k <= 12; k++) begin
      put_sample(rep(8'(k)), 1'b1, k == 10);
      if (k == 11) check("wrap in post", 32'(bus.state), 32'(ST_POST));
    end
    check("wrap to dump", 32'(bus.state), 32'(ST_DUMP));
    build_exp("wrap");
    run_dump("wrap", 0);

    // Qualifier; arm+trig together in IDLE only arms
    do_arm(1'b1);
    check("qual arm only state", 32'(bus.state), 32'(ST_CAPTURE));
    check("qual arm only count", 32'(bus.count), 32'd0);
    bus.post_cnt = '0;
    put_sample(rep(8'hA1), 1'b1, 1'b0);
    put_sample(rep(8'hA2), 1'b0, 1'b1);
    put_sample(rep(8'hA3), 1'b1, 1'b0);
    put_sample(rep(8'hA4), 1'b0, 1'b1);
    check("qual state", 32'(bus.state), 32'(ST_CAPTURE));
    check("qual count", 32'(bus.count), 32'd2);
    put_sample(rep(8'hA5), 1'b1, 1'b1);
    build_exp("qual");
    run_dump("qual", 0);

    // Backpressure
    do_arm(1'b0);
    bus.post_cnt = AW'(1);
    for (int k = 0; k < 5; k++) put_sample(rep(8'(8'h40 + k)), 1'b1, k == 3);
    build_exp("bp");
    run_dump("bp", 1);

    // Restart during POST
    do_arm(1'b0);
    bus.post_cnt = AW'(3);
    put_sample(rep(8'h71), 1'b1, 1'b0);
    put_sample(rep(8'h72), 1'b1, 1'b1);
    put_sample(rep(8'h73), 1'b1, 1'b0);
    check("restart in post", 32'(bus.state), 32'(ST_POST));
    bus.probe = rep(8'h74);
    do_arm(1'b0);
    check("restart count", 32'(bus.count), 32'd0);
    check("restart state", 32'(bus.state), 32'(ST_CAPTURE));
    bus.post_cnt = '0;
    put_sample(rep(8'h81), 1'b1, 1'b0);
    put_sample(rep(8'h82), 1'b1, 1'b1);
    build_exp("restart");
    run_dump("restart", 0);

    // Randomized captures
    for (int it = 0; it < 6; it++) begin
      int trig_idx, post, guard;
      logic en, tr;
      do_arm(1'b0);
      post = $urandom_range(0, DEPTH - 1);
      bus.post_cnt = AW'(post);
      trig_idx = -1;
      guard = 0;
      while (!(trig_idx >= 0 && hist.size() == trig_idx + 1 + post) && guard < 200) begin
        en = ($urandom_range(0, 3) != 0);
        tr = ($urandom_range(0, 9) == 0) || (guard > 30);
        put_sample(SW'($urandom), en, tr);
        if (trig_idx < 0 && en && tr) trig_idx = hist.size() - 1;
        guard++;
      end
      check("rand to dump", 32'(bus.state), 32'(ST_DUMP));
      build_exp("rand");
      run_dump("rand", 2);
    end

    // Reset mid-dump aborts immediately
    do_arm(1'b0);
    bus.post_cnt = '0;
    put_sample(rep(8'h55), 1'b1, 1'b0);
    put_sample(rep(8'h66), 1'b1, 1'b1);
    cycle();
    cycle();
    check("pre-reset valid", 32'(bus.rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset state", 32'(bus.state), 32'(ST_IDLE));
    check("midreset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("midreset rd_data", 32'(bus.rd_data), 32'd0);
    check("midreset rd_last", 32'(bus.rd_last), 32'd0);
    check("midreset count", 32'(bus.count), 32'd0);
    check("midreset wrapped", 32'(bus.wrapped), 32'd0);
    cycle();
    rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    repeat (3) cycle();
    check("postreset no resume", 32'(bus.rd_valid), 32'd0);
    check("postreset state", 32'(bus.state), 32'(ST_IDLE));
    bus.rd_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
